// File: rtl/instruction_sequencer_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: FSM states and
// the PC / writeback mux selects it drives into the datapath.
package instruction_sequencer_pkg;

    localparam int STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } sequencer_state_t;

    typedef enum logic [1:0] {
        PC_PLUS4    = 2'd0,
        PC_REL_IMM  = 2'd1,
        PC_RS1_IMM  = 2'd2,
        PC_RESERVED = 2'd3
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU      = 2'd0,
        WB_LOAD     = 2'd1,
        WB_PC4      = 2'd2,
        WB_RESERVED = 2'd3
    } wb_sel_t;

endpackage

// File: rtl/instruction_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control FSM for the RV32I core.
// Optional perf counters are enabled with the SEQUENCER_PERF_COUNTERS_EN macro.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int COUNTER_WIDTH       = 32,
    parameter bit HALT_ON_ENVIRONMENT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       ir_load,
    input  logic       load,
    input  logic       store,
    input  logic       branch,
    input  logic       immediate_jump,
    input  logic       register_jump,
    input  logic       environment,
    input  logic       opcode_legal,
    input  logic       write_register_valid,
    input  logic       branch_taken,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       pc_write,
    output logic [1:0] pc_sel,
    output logic       rf_write,
    output logic [1:0] wb_sel,
    output logic       halted,
`ifdef SEQUENCER_PERF_COUNTERS_EN
    output logic [COUNTER_WIDTH-1:0] cycle_count,
    output logic [COUNTER_WIDTH-1:0] retired_count,
`endif
    output logic [2:0] state
);

    if (COUNTER_WIDTH < 1) begin : g_bad_counter_width
        $error("instruction_sequencer: COUNTER_WIDTH must be at least 1");
    end

    sequencer_state_t state_reg;
    sequencer_state_t state_next;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH: begin
                if (imem_ack) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (!opcode_legal) begin
                    state_next = ST_HALT;
                end else if (environment) begin
                    state_next = HALT_ON_ENVIRONMENT ? ST_HALT : ST_WRITEBACK;
                end else begin
                    state_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                state_next = (load || store) ? ST_MEMORY : ST_WRITEBACK;
            end
            ST_MEMORY: begin
                // A completed store has nothing left to write back.
                if (dmem_ack) state_next = store ? ST_FETCH : ST_WRITEBACK;
            end
            ST_WRITEBACK: state_next = ST_FETCH;
            ST_HALT:      state_next = ST_HALT;
            default:      state_next = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Enables are decoded straight from state so reset drops requests at once.
    always_comb begin
        imem_req = 1'b0;
        ir_load  = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = PC_PLUS4;
        rf_write = 1'b0;
        wb_sel   = WB_ALU;
        halted   = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            ST_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = store;
                pc_write = dmem_ack && store;
            end
            ST_WRITEBACK: begin
                pc_write = 1'b1;
                rf_write = write_register_valid;
                if (register_jump) begin
                    pc_sel = PC_RS1_IMM;
                end else if (immediate_jump || (branch && branch_taken)) begin
                    pc_sel = PC_REL_IMM;
                end
                if (load) begin
                    wb_sel = WB_LOAD;
                end else if (immediate_jump || register_jump) begin
                    wb_sel = WB_PC4;
                end
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign state = state_reg;

`ifdef SEQUENCER_PERF_COUNTERS_EN
    localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    logic [COUNTER_WIDTH-1:0] cycle_count_reg;
    logic [COUNTER_WIDTH-1:0] retired_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count_reg   <= '0;
            retired_count_reg <= '0;
        end else begin
            if (state_reg != ST_HALT) cycle_count_reg <= cycle_count_reg + COUNT_ONE;
            if (pc_write) retired_count_reg <= retired_count_reg + COUNT_ONE;
        end
    end

    assign cycle_count   = cycle_count_reg;
    assign retired_count = retired_count_reg;
`endif

endmodule
